fifo_write_arbiter: RTL and testbench

//  Shares the single write port of the async FIFO write side among NUM_REQ requesters, all on write_clk.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_write_arbiter_if.sv | 44 ++++
 rtl/fifo_write_arbiter_picker.sv | 28 ++
 rtl/fifo_write_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the async FIFO write-side arbiter.
package fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester/write-controller bundle of the FIFO write arbiter.
// FIFO_WRARB_STATS_EN adds the stall_count statistic.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    import fifo_pkg::*;

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_write_en;
    logic [DATA_WIDTH-1:0]         fifo_write_data;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;
`ifdef FIFO_WRARB_STATS_EN
    logic [15:0]                   stall_count;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_write_en, fifo_write_data, grant_id, busy, stall_count
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_write_en, fifo_write_data, grant_id, busy, stall_count
    );
`else
    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_write_en, fifo_write_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_write_en, fifo_write_data, grant_id, busy
    );
`endif

endinterface

// File: rtl/fifo_write_arbiter_picker.sv
// Rotating priority encoder: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
module wr_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               any,
    output logic [ID_W-1:0]    index
);

    int idx;

    // Scan farthest-to-nearest so the nearest hit is the one left standing.
    always_comb begin
        any   = 1'b0;
        index = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                any   = 1'b1;
                index = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-locked arbiter for the async FIFO write port.
// FIFO_WRARB_STATS_EN adds a saturating 16-bit stall counter on the interface.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8
) (
    input  logic               write_clk,
    input  logic               write_rst_n,
    fifo_write_arbiter_if.slave bus
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    arb_state_t       state;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  next_ptr;
    logic [ID_W-1:0]  pick_idx;
    logic [CNT_W-1:0] beat_cnt;
    logic             pick_any;
    logic             busy_q;
    logic             accept;
    logic             pkt_end;

    wr_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .index  (pick_idx)
    );

    assign accept   = busy_q & bus.req_valid[grant_id] & ~bus.fifo_full;
    assign pkt_end  = bus.req_last[grant_id] | (beat_cnt == LAST_CNT);
    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Grant is held until the owner's last beat or the burst cap, then the
    // pointer moves past the owner so everyone else gets a turn first.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= BUSY;
                        busy_q   <= 1'b1;
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        if (pkt_end) begin
                            state    <= IDLE;
                            busy_q   <= 1'b0;
                            rr_ptr   <= next_ptr;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready       = accept ? (NUM_REQ'(1) << grant_id) : '0;
    assign bus.fifo_write_en   = accept;
    assign bus.fifo_write_data = busy_q ? bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.grant_id        = grant_id;
    assign bus.busy            = busy_q;

`ifdef FIFO_WRARB_STATS_EN
    logic [15:0] stall_count;

    // Counts cycles the owner had a beat ready but the FIFO was full.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            stall_count <= '0;
        end else if (busy_q && bus.req_valid[grant_id] && bus.fifo_full
                     && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    assign bus.stall_count = stall_count;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: per-requester beat queues drive the bus,
// expected writes are queued up front and popped on every fifo_write_en.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 8;
    localparam int QD = 32;

    logic write_clk   = 1'b0;
    logic write_rst_n = 1'b0;

    always #5 write_clk = ~write_clk;

    fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();

    fifo_write_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .write_clk   (write_clk),
        .write_rst_n (write_rst_n),
        .bus         (bus)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       last_exit;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] bData [NR][QD];
    logic       bLast [NR][QD];
    int         bGap  [NR][QD];
    int         head [NR];
    int         tail [NR];
    int         gapLeft [NR];
    int         fullStart = -1;
    int         fullLen   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic loadPacket(input int id, input int firstSeq, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            bData[id][tail[id]] = 8'(id * 64 + firstSeq + k);
            bLast[id][tail[id]] = (k == n - 1);
            bGap[id][tail[id]]  = (k == 0) ? 0 : gap;
            tail[id]++;
        end
    endtask

    task automatic pushExpected(input int id, input int firstSeq, input int n, input bit exitAtEnd);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.id        = 2'(id);
            e.data      = 8'(id * 64 + firstSeq + k);
            e.last_exit = exitAtEnd && (k == n - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic clearQueues();
        for (int i = 0; i < NR; i++) begin
            head[i]    = 0;
            tail[i]    = 0;
            gapLeft[i] = 0;
        end
        expQ.delete();
        fullStart = -1;
        fullLen   = 0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, bus.req_ready, 0);
        checkOutput({tag, "_wr_en"}, bus.fifo_write_en, 0);
        checkOutput({tag, "_busy"},  bus.busy, 0);
        checkOutput({tag, "_grant"}, bus.grant_id, 0);
        checkOutput({tag, "_data"},  bus.fifo_write_data, 0);
`ifdef FIFO_WRARB_STATS_EN
        checkOutput({tag, "_stall"}, bus.stall_count, 0);
`endif
    endtask

    // Reset is asserted with every requester shouting so reset dominance is visible.
    task automatic doReset(input string tag);
        @(negedge write_clk);
        write_rst_n   = 1'b0;
        bus.req_valid = '1;
        bus.req_last  = '1;
        bus.req_data  = '1;
        bus.fifo_full = 1'b0;
        #1;
        checkResetOutputs({tag, "_now"});
        repeat (2) @(negedge write_clk);
        checkResetOutputs({tag, "_held"});
        clearQueues();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        @(negedge write_clk);
        write_rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input int maxCycles, input bit expectDrain);
        int          cyc      = 0;
        int          extra    = 0;
        int          pending  = 0;
        bit          prevExit = 1'b0;
        logic [NR-1:0] adv;
        exp_t        e;
        for (int i = 0; i < NR; i++)
            gapLeft[i] = (head[i] < tail[i]) ? bGap[i][head[i]] : 0;
        while (cyc < maxCycles && extra < 3) begin
            @(negedge write_clk);
            for (int i = 0; i < NR; i++) begin
                if (head[i] < tail[i] && gapLeft[i] == 0) begin
                    bus.req_valid[i]          = 1'b1;
                    bus.req_last[i]           = bLast[i][head[i]];
                    bus.req_data[i*DW +: DW]  = bData[i][head[i]];
                end else begin
                    bus.req_valid[i]          = 1'b0;
                    bus.req_last[i]           = 1'b0;
                    bus.req_data[i*DW +: DW]  = '0;
                    if (head[i] < tail[i]) gapLeft[i]--;
                end
            end
            bus.fifo_full = (cyc >= fullStart) && (cyc < fullStart + fullLen);
            #4;
            adv = '0;
            if (bus.fifo_full)
                checkOutput("no_write_when_full", bus.fifo_write_en, 0);
            if (fullLen > 0 && cyc == fullStart + fullLen)
                checkOutput("resume_after_full", bus.fifo_write_en, 1);
            if (bus.fifo_write_en) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write", bus.fifo_write_en, 0);
                    prevExit = 1'b0;
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wr_id",        bus.grant_id,        e.id);
                    checkOutput("wr_data",      bus.fifo_write_data, e.data);
                    checkOutput("ready_onehot", bus.req_ready,       4'b0001 << e.id);
                    prevExit = e.last_exit;
                end
                adv = bus.req_ready;
            end else begin
                checkOutput("ready_idle", bus.req_ready, 0);
                if (prevExit)
                    checkOutput("bubble", {bus.busy, bus.fifo_write_en}, 0);
                prevExit = 1'b0;
            end
            @(posedge write_clk);
            for (int i = 0; i < NR; i++) begin
                if (adv[i] && head[i] < tail[i]) begin
                    head[i]++;
                    gapLeft[i] = (head[i] < tail[i]) ? bGap[i][head[i]] : 0;
                end
            end
            pending = 0;
            for (int i = 0; i < NR; i++) pending += tail[i] - head[i];
            if (pending == 0) extra++;
            cyc++;
        end
        if (expectDrain)
            checkOutput("drain_pending", pending, 0);
        checkOutput("sb_left", expQ.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        clearQueues();

        $display("[TB] reset with all requesters valid");
        doReset("rst");

        $display("[TB] round-robin single-beat packets");
        loadPacket(0, 0, 1, 0);
        loadPacket(0, 1, 1, 0);
        loadPacket(1, 0, 1, 0);
        loadPacket(2, 0, 1, 0);
        loadPacket(3, 0, 1, 0);
        pushExpected(0, 0, 1, 1);
        pushExpected(1, 0, 1, 1);
        pushExpected(2, 0, 1, 1);
        pushExpected(3, 0, 1, 1);
        pushExpected(0, 1, 1, 1);
        applyStimulus(100, 1);

        $display("[TB] packet lock with valid gaps");
        doReset("rst2");
        loadPacket(0, 0, 3, 2);
        loadPacket(1, 0, 1, 0);
        pushExpected(0, 0, 3, 1);
        pushExpected(1, 0, 1, 1);
        applyStimulus(100, 1);

        $display("[TB] burst cap");
        doReset("rst3");
        loadPacket(2, 0, 20, 0);
        loadPacket(3, 0, 2, 0);
        pushExpected(2, 0, 8, 1);
        pushExpected(3, 0, 2, 1);
        pushExpected(2, 8, 8, 1);
        pushExpected(2, 16, 4, 1);
        applyStimulus(100, 1);

        $display("[TB] backpressure mid-packet");
        doReset("rst4");
        loadPacket(1, 0, 10, 0);
        pushExpected(1, 0, 8, 1);
        pushExpected(1, 8, 2, 1);
        fullStart = 3;
        fullLen   = 5;
        applyStimulus(100, 1);
`ifdef FIFO_WRARB_STATS_EN
        checkOutput("stall_count", bus.stall_count, 5);
`endif
        fullStart = -1;
        fullLen   = 0;

        $display("[TB] reset mid-packet");
        doReset("rst5");
        loadPacket(1, 0, 1, 0);
        loadPacket(2, 0, 4, 0);
        pushExpected(1, 0, 1, 1);
        pushExpected(2, 0, 1, 0);
        applyStimulus(4, 0);
        doReset("rst_mid");
        loadPacket(0, 0, 1, 0);
        loadPacket(3, 0, 1, 0);
        pushExpected(0, 0, 1, 1);
        pushExpected(3, 0, 1, 1);
        applyStimulus(100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
